// File: rtl/alu_op_decoder.sv
// RV32I decode stage: turns an instruction/PC into ALU opcode, operand selects,
// immediate and illegal flag, behind a main register plus one skid entry.
module alu_op_decoder #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_instr,
  input  logic [XLEN-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_alu_ctrl,
  output logic [1:0]        out_a_sel,
  output logic              out_b_sel,
  output logic [XLEN-1:0]   out_imm,
  output logic              out_illegal,
  output logic [XLEN-1:0]   out_pc
);

  typedef enum logic [CTRL_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SRA  = 4'd3,
    ALU_SRL  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_SLT  = 4'd7,
    ALU_SLTU = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [1:0] A_RS1  = 2'd0;
  localparam logic [1:0] A_PC   = 2'd1;
  localparam logic [1:0] A_ZERO = 2'd2;

  typedef struct packed {
    logic [CTRL_W-1:0] alu_ctrl;
    logic [1:0]        a_sel;
    logic              b_sel;
    logic [XLEN-1:0]   imm;
    logic              illegal;
  } dec_t;

  typedef struct packed {
    dec_t            dec;
    logic [XLEN-1:0] pc;
  } entry_t;

  function automatic logic signed [XLEN-1:0] imm_i(input logic [XLEN-1:0] i);
    return {{20{i[31]}}, i[31:20]};
  endfunction

  function automatic logic signed [XLEN-1:0] imm_s(input logic [XLEN-1:0] i);
    return {{20{i[31]}}, i[31:25], i[11:7]};
  endfunction

  function automatic logic signed [XLEN-1:0] imm_b(input logic [XLEN-1:0] i);
    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
  endfunction

  function automatic logic signed [XLEN-1:0] imm_u(input logic [XLEN-1:0] i);
    return {i[31:12], 12'b0};
  endfunction

  function automatic logic signed [XLEN-1:0] imm_j(input logic [XLEN-1:0] i);
    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
  endfunction

  // Shared funct3 map for R-type and I-ALU; callers resolve ADD/SUB and SRL/SRA.
  function automatic logic [CTRL_W-1:0] alu_from_f3(input logic [2:0] f3);
    logic [CTRL_W-1:0] op;
    case (f3)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  function automatic dec_t decode(input logic [XLEN-1:0] instr);
    dec_t       d;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    opcode = instr[6:0];
    funct3 = instr[14:12];
    funct7 = instr[31:25];
    d = '0;
    case (opcode)
      OP_R: begin
        d.a_sel = A_RS1;
        d.b_sel = 1'b0;
        if (funct3 == 3'b000 || funct3 == 3'b101) begin
          if (funct7 == F7_BASE)     d.alu_ctrl = alu_from_f3(funct3);
          else if (funct7 == F7_ALT) d.alu_ctrl = (funct3 == 3'b000) ? ALU_SUB : ALU_SRA;
          else                       d.illegal  = 1'b1;
        end else if (funct7 == F7_BASE) begin
          d.alu_ctrl = alu_from_f3(funct3);
        end else begin
          d.illegal = 1'b1;
        end
      end
      OP_I: begin
        d.a_sel    = A_RS1;
        d.b_sel    = 1'b1;
        d.imm      = imm_i(instr);
        d.alu_ctrl = alu_from_f3(funct3);
        // Shift-immediates carry the shift amount alone; imm[11:5] is an opcode extension.
        if (funct3 == 3'b001) begin
          d.imm = {27'b0, instr[24:20]};
          if (funct7 != F7_BASE) d.illegal = 1'b1;
        end else if (funct3 == 3'b101) begin
          d.imm = {27'b0, instr[24:20]};
          if (funct7 == F7_ALT)       d.alu_ctrl = ALU_SRA;
          else if (funct7 != F7_BASE) d.illegal  = 1'b1;
        end
      end
      OP_LOAD: begin
        d.alu_ctrl = ALU_ADD;
        d.a_sel    = A_RS1;
        d.b_sel    = 1'b1;
        d.imm      = imm_i(instr);
      end
      OP_STORE: begin
        d.alu_ctrl = ALU_ADD;
        d.a_sel    = A_RS1;
        d.b_sel    = 1'b1;
        d.imm      = imm_s(instr);
      end
      OP_BRANCH: begin
        d.a_sel = A_RS1;
        d.b_sel = 1'b0;
        d.imm   = imm_b(instr);
        case (funct3)
          3'b000, 3'b001: d.alu_ctrl = ALU_SUB;
          3'b100, 3'b101: d.alu_ctrl = ALU_SLT;
          3'b110, 3'b111: d.alu_ctrl = ALU_SLTU;
          default:        d.illegal  = 1'b1;
        endcase
      end
      OP_LUI: begin
        d.alu_ctrl = ALU_ADD;
        d.a_sel    = A_ZERO;
        d.b_sel    = 1'b1;
        d.imm      = imm_u(instr);
      end
      OP_AUIPC: begin
        d.alu_ctrl = ALU_ADD;
        d.a_sel    = A_PC;
        d.b_sel    = 1'b1;
        d.imm      = imm_u(instr);
      end
      OP_JAL: begin
        d.alu_ctrl = ALU_ADD;
        d.a_sel    = A_PC;
        d.b_sel    = 1'b1;
        d.imm      = imm_j(instr);
      end
      OP_JALR: begin
        d.alu_ctrl = ALU_ADD;
        d.a_sel    = A_RS1;
        d.b_sel    = 1'b1;
        d.imm      = imm_i(instr);
        if (funct3 != 3'b000) d.illegal = 1'b1;
      end
      default: d.illegal = 1'b1;
    endcase
    // Illegal entries still travel downstream, but with every control field neutral.
    if (d.illegal) begin
      d         = '0;
      d.illegal = 1'b1;
    end
    return d;
  endfunction

  entry_t ent_p0;
  entry_t ent_p1;
  entry_t skid_p1;
  logic   vld_p1;
  logic   vld_skid_p1;
  logic   accept;
  logic   consume;

  always_comb begin
    ent_p0.dec = decode(in_instr);
    ent_p0.pc  = in_pc;
  end

  assign accept  = in_valid && in_ready && !flush;
  assign consume = vld_p1 && out_ready;

  // ---- stage p0 -> p1: main register with one skid entry behind it ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_p1      <= '0;
      skid_p1     <= '0;
      vld_p1      <= 1'b0;
      vld_skid_p1 <= 1'b0;
      in_ready    <= 1'b1;
    end else if (flush) begin
      ent_p1      <= '0;
      skid_p1     <= '0;
      vld_p1      <= 1'b0;
      vld_skid_p1 <= 1'b0;
      in_ready    <= 1'b1;
    end else if (vld_skid_p1 && consume) begin
      // in_ready is low while the skid is full, so no accept can coincide here.
      ent_p1      <= skid_p1;
      vld_skid_p1 <= 1'b0;
      in_ready    <= 1'b1;
    end else if (!vld_p1 || consume) begin
      if (accept) begin
        ent_p1 <= ent_p0;
        vld_p1 <= 1'b1;
      end else begin
        vld_p1 <= 1'b0;
      end
    end else if (accept) begin
      skid_p1     <= ent_p0;
      vld_skid_p1 <= 1'b1;
      in_ready    <= 1'b0;
    end
  end

  assign out_valid    = vld_p1;
  assign out_alu_ctrl = ent_p1.dec.alu_ctrl;
  assign out_a_sel    = ent_p1.dec.a_sel;
  assign out_b_sel    = ent_p1.dec.b_sel;
  assign out_imm      = ent_p1.dec.imm;
  assign out_illegal  = ent_p1.dec.illegal;
  assign out_pc       = ent_p1.pc;

endmodule

// File: tb/tb_alu_op_decoder.sv
// Directed bench for alu_op_decoder: decode vectors, backpressure/skid, flush and reset.
module tb_alu_op_decoder;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_alu_ctrl;
  logic [1:0]  out_a_sel;
  logic        out_b_sel;
  logic [31:0] out_imm;
  logic        out_illegal;
  logic [31:0] out_pc;

  int checks   = 0;
  int failures = 0;

  alu_op_decoder #(.XLEN(32), .CTRL_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .in_pc        (in_pc),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_alu_ctrl (out_alu_ctrl),
    .out_a_sel    (out_a_sel),
    .out_b_sel    (out_b_sel),
    .out_imm      (out_imm),
    .out_illegal  (out_illegal),
    .out_pc       (out_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Checks a full decoded output slot, including out_valid=1.
  task automatic chk_out(input string tag, input logic [3:0] alu, input logic [1:0] asel,
                         input logic bsel, input logic [31:0] imm, input logic ill,
                         input logic [31:0] pc);
    chk({tag, ".valid"}, {31'b0, out_valid}, 32'd1);
    chk({tag, ".alu"}, {28'b0, out_alu_ctrl}, {28'b0, alu});
    chk({tag, ".asel"}, {30'b0, out_a_sel}, {30'b0, asel});
    chk({tag, ".bsel"}, {31'b0, out_b_sel}, {31'b0, bsel});
    chk({tag, ".imm"}, out_imm, imm);
    chk({tag, ".ill"}, {31'b0, out_illegal}, {31'b0, ill});
    chk({tag, ".pc"}, out_pc, pc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] instr, input logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_pc     = '0;
    out_ready = 1'b1;
    #12;
    chk("rst.valid", {31'b0, out_valid}, 32'd0);
    chk("rst.ready", {31'b0, in_ready}, 32'd1);
    chk("rst.imm", out_imm, 32'd0);
    chk("rst.pc", out_pc, 32'd0);
    chk("rst.alu", {28'b0, out_alu_ctrl}, 32'd0);
    rst = 1'b0;

    // Streaming decode, one instruction per cycle with out_ready high.
    send(32'h002081B3, 32'h100); tick();
    chk_out("add", 4'd0, 2'd0, 1'b0, 32'h0, 1'b0, 32'h100);
    send(32'h402081B3, 32'h104); tick();
    chk_out("sub", 4'd1, 2'd0, 1'b0, 32'h0, 1'b0, 32'h104);
    send(32'h40315093, 32'h108); tick();
    chk_out("srai", 4'd3, 2'd0, 1'b1, 32'h3, 1'b0, 32'h108);
    send(32'h0020E463, 32'h10C); tick();
    chk_out("bltu", 4'd8, 2'd0, 1'b0, 32'h8, 1'b0, 32'h10C);
    send(32'h123450B7, 32'h110); tick();
    chk_out("lui", 4'd0, 2'd2, 1'b1, 32'h12345000, 1'b0, 32'h110);
    send(32'h0000007F, 32'h114); tick();
    chk_out("badop", 4'd0, 2'd0, 1'b0, 32'h0, 1'b1, 32'h114);
    send(32'hC02081B3, 32'h118); tick();
    chk_out("badf7", 4'd0, 2'd0, 1'b0, 32'h0, 1'b1, 32'h118);
    // auipc x1, 0xFFFFF -> negative U immediate, operand A from PC
    send(32'hFFFFF097, 32'h11C); tick();
    chk_out("auipc", 4'd0, 2'd1, 1'b1, 32'hFFFFF000, 1'b0, 32'h11C);
    // jal x0, -4 -> J immediate 0xFFFFFFFC
    send(32'hFFDFF06F, 32'h120); tick();
    chk_out("jal", 4'd0, 2'd1, 1'b1, 32'hFFFFFFFC, 1'b0, 32'h120);
    // sw x2, -8(x1) -> S immediate 0xFFFFFFF8
    send(32'hFE20AC23, 32'h124); tick();
    chk_out("sw", 4'd0, 2'd0, 1'b1, 32'hFFFFFFF8, 1'b0, 32'h124);
    // jalr with funct3=001 is not a valid encoding
    send(32'h000090E7, 32'h128); tick();
    chk_out("badjalr", 4'd0, 2'd0, 1'b0, 32'h0, 1'b1, 32'h128);
    in_valid = 1'b0; tick();
    chk("drain.valid", {31'b0, out_valid}, 32'd0);

    // Backpressure: A held in main register, B parked in skid.
    out_ready = 1'b0;
    send(32'h002081B3, 32'h200); tick();
    chk_out("bpA", 4'd0, 2'd0, 1'b0, 32'h0, 1'b0, 32'h200);
    chk("bpA.ready", {31'b0, in_ready}, 32'd1);
    send(32'h123450B7, 32'h204); tick();
    chk_out("bpHold1", 4'd0, 2'd0, 1'b0, 32'h0, 1'b0, 32'h200);
    chk("bpSkid.ready", {31'b0, in_ready}, 32'd0);
    send(32'h402081B3, 32'h208); tick();
    chk_out("bpHold2", 4'd0, 2'd0, 1'b0, 32'h0, 1'b0, 32'h200);
    chk("bpHold2.ready", {31'b0, in_ready}, 32'd0);
    in_valid  = 1'b0;
    out_ready = 1'b1; tick();
    chk_out("bpB", 4'd0, 2'd2, 1'b1, 32'h12345000, 1'b0, 32'h204);
    chk("bpB.ready", {31'b0, in_ready}, 32'd1);
    tick();
    chk("bpDone.valid", {31'b0, out_valid}, 32'd0);

    // Flush with main and skid full while in_valid is high.
    out_ready = 1'b0;
    send(32'h002081B3, 32'h300); tick();
    send(32'h402081B3, 32'h304); tick();
    chk("fl.full.ready", {31'b0, in_ready}, 32'd0);
    flush = 1'b1;
    send(32'h123450B7, 32'h308); tick();
    chk("fl.valid", {31'b0, out_valid}, 32'd0);
    chk("fl.ready", {31'b0, in_ready}, 32'd1);
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1; tick();
    chk("fl.after.valid", {31'b0, out_valid}, 32'd0);

    // Flush coinciding with an otherwise-legal accept discards it.
    out_ready = 1'b0;
    send(32'h002081B3, 32'h400); tick();
    flush = 1'b1;
    send(32'h402081B3, 32'h404); tick();
    chk("fl2.valid", {31'b0, out_valid}, 32'd0);
    flush    = 1'b0;
    in_valid = 1'b0; tick();
    chk("fl2.after.valid", {31'b0, out_valid}, 32'd0);

    // Asynchronous reset between clock edges.
    out_ready = 1'b0;
    send(32'h123450B7, 32'h500); tick();
    chk_out("prerst", 4'd0, 2'd2, 1'b1, 32'h12345000, 1'b0, 32'h500);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst.valid", {31'b0, out_valid}, 32'd0);
    chk("arst.imm", out_imm, 32'd0);
    chk("arst.pc", out_pc, 32'd0);
    chk("arst.asel", {30'b0, out_a_sel}, 32'd0);
    chk("arst.ready", {31'b0, in_ready}, 32'd1);
    #2 rst = 1'b0;
    out_ready = 1'b1;
    send(32'h402081B3, 32'h600); tick();
    chk_out("postrst", 4'd1, 2'd0, 1'b0, 32'h0, 1'b0, 32'h600);
    in_valid = 1'b0; tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
